// File: rtl/sm_pkg.sv
// Shared definitions for the result side of the string matcher: record layout,
// reserved position code and collector FSM encoding (also used by the host decoder).
package sm_pkg;

    localparam int unsigned GROUPS     = 4;
    localparam int unsigned NUM        = 4;
    localparam int unsigned POS_W      = 8;
    localparam int unsigned ID_W       = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned REC_W      = ID_W + GROUPS + GROUPS * POS_W;

    localparam logic [POS_W-1:0] NO_HIT = '1;

    // Record = {id, hit_mask, pos[GROUPS-1], ..., pos[0]}
    localparam int unsigned MASK_LSB = GROUPS * POS_W;
    localparam int unsigned ID_LSB   = MASK_LSB + GROUPS;

    function automatic int unsigned pos_lsb(input int unsigned g);
        return g * POS_W;
    endfunction

    typedef enum logic {
        StIdle    = 1'b0,
        StCollect = 1'b1
    } state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous record FIFO with registered head; the head holds its last value when empty
// and a push into a full FIFO is dropped and flagged sticky.
module result_fifo #(
    parameter int unsigned Width = 44,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             ready_i,
    output logic [Width-1:0] rdata_o,
    output logic             valid_o,
    output logic             overflow_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
    logic [Width-1:0] head_q, head_d;
    logic             ovf_q;
    logic             empty, full, push_ok, pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push_i & ~full;
    assign pop     = ~empty & ready_i;

    always_comb begin
        wr_d   = wr_q + {{AW{1'b0}}, push_ok};
        rd_d   = rd_q + {{AW{1'b0}}, pop};
        head_d = head_q;
        // Preload the next head so it is valid the same cycle rec_valid rises.
        if (wr_d != rd_d) begin
            if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
            if (push_i && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign rdata_o    = head_q;
    assign valid_o    = ~empty;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/output_controller.sv
// Collects per-string match results (id, group hit mask, first-hit positions) from the
// match array and queues one record per completed string for a valid/ready consumer.
module output_controller
    import sm_pkg::*;
#(
    parameter int unsigned groups               = sm_pkg::GROUPS,
    parameter int unsigned num                  = sm_pkg::NUM,
    parameter int unsigned max_number_of_weight = num * groups,
    parameter int unsigned POS_W                = sm_pkg::POS_W,
    parameter int unsigned ID_W                 = sm_pkg::ID_W,
    parameter int unsigned FIFO_DEPTH           = sm_pkg::FIFO_DEPTH,
    localparam int unsigned REC_W               = ID_W + groups + groups * POS_W
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            string_ready_i,
    input  logic [groups:0]                 done_i,
    input  logic [max_number_of_weight-1:0] en_i,
    input  logic [max_number_of_weight-1:0] router_output_i,
    output logic [REC_W-1:0]                rec_data_o,
    output logic                            rec_valid_o,
    input  logic                            rec_ready_i,
    output logic                            overflow_o,
    output logic                            busy_o
);
    localparam logic [POS_W-1:0] NoHit  = '1;
    localparam logic [POS_W-1:0] PosMax = {{(POS_W-1){1'b1}}, 1'b0};

    state_e                        state_q;
    logic [POS_W-1:0]              pos_cnt_q;
    logic [groups-1:0]             mask_q, mask_cap, hit;
    logic [groups-1:0][POS_W-1:0]  pos_q, pos_cap;
    logic [ID_W-1:0]               id_q;
    logic                          end_str;

    // Captured view includes this cycle's hits so the end cycle's hits reach the record.
    always_comb begin
        for (int g = 0; g < groups; g++) begin
            hit[g]      = (&router_output_i[g*num +: num]) | done_i[g];
            mask_cap[g] = mask_q[g] | hit[g];
            pos_cap[g]  = (hit[g] && !mask_q[g]) ? pos_cnt_q : pos_q[g];
        end
        end_str = (state_q == StCollect) && done_i[groups] && !string_ready_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            pos_cnt_q <= '0;
            mask_q    <= '0;
            pos_q     <= {groups{NoHit}};
            id_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (string_ready_i) begin
                        state_q   <= StCollect;
                        pos_cnt_q <= '0;
                        mask_q    <= '0;
                        pos_q     <= {groups{NoHit}};
                    end
                end
                StCollect: begin
                    if (string_ready_i) begin
                        pos_cnt_q <= '0;
                        mask_q    <= '0;
                        pos_q     <= {groups{NoHit}};
                    end else if (done_i[groups]) begin
                        id_q    <= id_q + 1'b1;
                        state_q <= StIdle;
                    end else begin
                        mask_q <= mask_cap;
                        pos_q  <= pos_cap;
                        if ((|en_i) && (pos_cnt_q != PosMax)) begin
                            pos_cnt_q <= pos_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q == StCollect);

    result_fifo #(
        .Width (REC_W),
        .Depth (FIFO_DEPTH)
    ) u_result_fifo (
        .clk_i      (clk_i),
        .rst_i      (reset_i),
        .push_i     (end_str),
        .wdata_i    ({id_q, mask_cap, pos_cap}),
        .ready_i    (rec_ready_i),
        .rdata_o    (rec_data_o),
        .valid_o    (rec_valid_o),
        .overflow_o (overflow_o)
    );

endmodule

// File: tb/tb_output_controller.sv
// Directed and random checks of output_controller against a history-based record model.
module tb_output_controller;

    localparam int G  = 4;
    localparam int N  = 4;
    localparam int L  = G * N;
    localparam int PW = 8;
    localparam int IW = 8;
    localparam int RW = IW + G + G * PW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          string_ready = 1'b0;
    logic [G:0]    done = '0;
    logic [L-1:0]  en = '0;
    logic [L-1:0]  router_output = '0;
    logic          rec_ready = 1'b0;
    logic [RW-1:0] rec_data;
    logic          rec_valid;
    logic          overflow;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_controller u_dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .string_ready_i  (string_ready),
        .done_i          (done),
        .en_i            (en),
        .router_output_i (router_output),
        .rec_data_o      (rec_data),
        .rec_valid_o     (rec_valid),
        .rec_ready_i     (rec_ready),
        .overflow_o      (overflow),
        .busy_o          (busy)
    );

    // Model: the string's step history; records derived from it when the string ends.
    bit            m_coll;
    logic [G-1:0]  h_q[$];
    bit            e_q[$];
    logic [RW-1:0] f_q[$];
    logic [RW-1:0] last_head;
    bit            m_ovf;
    logic [IW-1:0] m_id;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] build_rec();
        logic [G-1:0]    mask;
        logic [G*PW-1:0] p;
        logic [PW-1:0]   pv;
        int              cnt;
        mask = '0;
        for (int g = 0; g < G; g++) begin
            pv  = 8'hFF;
            cnt = 0;
            for (int i = 0; i < h_q.size(); i++) begin
                if (h_q[i][g] && !mask[g]) begin
                    mask[g] = 1'b1;
                    pv      = cnt[PW-1:0];
                end
                if (e_q[i] && cnt < 254) cnt++;
            end
            p[g*PW +: PW] = pv;
        end
        return {m_id, mask, p};
    endfunction

    function automatic void model_reset();
        m_coll = 0;
        h_q.delete();
        e_q.delete();
        f_q.delete();
        last_head = '0;
        m_ovf = 0;
        m_id = '0;
    endfunction

    function automatic void model_step(input logic sr, input logic [G:0] dn,
                                       input logic [L-1:0] e, input logic [L-1:0] r,
                                       input logic rdy);
        logic [G-1:0]  hv;
        logic [RW-1:0] prec;
        bit            push, pop, full;
        for (int g = 0; g < G; g++) hv[g] = (&r[g*N +: N]) | dn[g];
        pop  = (f_q.size() > 0) && rdy;
        full = (f_q.size() == 4);
        push = 0;
        prec = '0;
        if (sr) begin
            m_coll = 1;
            h_q.delete();
            e_q.delete();
        end else if (m_coll) begin
            h_q.push_back(hv);
            e_q.push_back(e != '0);
            if (dn[G]) begin
                prec = build_rec();
                push = 1;
                m_id = m_id + 1'b1;
                m_coll = 0;
            end
        end
        if (pop) void'(f_q.pop_front());
        if (push) begin
            if (full) m_ovf = 1;
            else f_q.push_back(prec);
        end
        if (f_q.size() > 0) last_head = f_q[0];
    endfunction

    task automatic compare_outputs();
        check("busy", busy, m_coll);
        check("rec_valid", rec_valid, f_q.size() > 0);
        check("rec_data", rec_data, last_head);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic cyc(input logic sr, input logic [G:0] dn, input logic [L-1:0] e,
                       input logic [L-1:0] r, input logic rdy);
        @(negedge clk);
        string_ready  = sr;
        done          = dn;
        en            = e;
        router_output = r;
        rec_ready     = rdy;
        @(posedge clk);
        model_step(sr, dn, e, r, rdy);
        #1;
        compare_outputs();
    endtask

    // Reset is raised between edges to observe its asynchronous effect.
    task automatic do_reset();
        @(negedge clk);
        string_ready = 0;
        done = '0;
        en = '0;
        router_output = '0;
        rec_ready = 0;
        #2 reset = 1;
        #1;
        model_reset();
        check("reset_busy", busy, 1'b0);
        check("reset_valid", rec_valid, 1'b0);
        check("reset_data", rec_data, '0);
        check("reset_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic short_string(input logic rdy);
        cyc(1, '0, '0, '0, rdy);
        cyc(0, '0, 16'h0001, '0, rdy);
        cyc(0, '0, 16'h0100, '0, rdy);
        cyc(0, 5'h10, '0, '0, rdy);
    endtask

    initial begin
        logic [G:0]   rdn;
        logic [L-1:0] rro;

        // 1: single group-2 hit at position 3
        do_reset();
        cyc(1, '0, '0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, '0, 16'h0001, (i == 3) ? 16'h0F00 : 16'h0000, 0);
        cyc(0, 5'h10, '0, '0, 0);
        check("t1_valid", rec_valid, 1'b1);
        check("t1_rec", rec_data, {8'd0, 4'b0100, 8'hFF, 8'd3, 8'hFF, 8'hFF});
        cyc(0, '0, '0, '0, 1);

        // 2: repeated hit ignored, done-based hit
        do_reset();
        cyc(1, '0, '0, '0, 0);
        for (int i = 0; i < 6; i++)
            cyc(0, (i == 1) ? 5'h01 : 5'h00, 16'h0002,
                (i == 2 || i == 4) ? 16'h00F0 : 16'h0000, 0);
        cyc(0, 5'h10, '0, '0, 0);
        check("t2_rec", rec_data, {8'd0, 4'b0011, 8'hFF, 8'hFF, 8'd2, 8'd1});

        // 3: overflow with a stalled consumer, then ordered drain
        do_reset();
        for (int s = 0; s < 5; s++) short_string(0);
        check("t3_ovf", overflow, 1'b1);
        check("t3_head_id", rec_data[RW-1 -: IW], 8'd0);
        for (int i = 0; i < 6; i++) cyc(0, '0, '0, '0, 1);
        check("t3_empty", rec_valid, 1'b0);

        // 4: load/done coincidence never ends a string; restart keeps the id
        do_reset();
        cyc(1, 5'h10, '0, '0, 0);
        check("t4_busy_load", busy, 1'b1);
        check("t4_no_push", rec_valid, 1'b0);
        cyc(0, '0, 16'h0001, 16'hF000, 0);
        cyc(1, 5'h10, '0, '0, 0);
        check("t4_abort_no_push", rec_valid, 1'b0);
        cyc(0, '0, 16'h0001, '0, 0);
        cyc(0, '0, 16'h0001, 16'h000F, 0);
        cyc(0, 5'h10, '0, '0, 0);
        check("t4_id", rec_data[RW-1 -: IW], 8'd0);
        check("t4_mask", rec_data[G*PW +: G], 4'b0001);

        // 5: position counter saturation
        do_reset();
        cyc(1, '0, '0, '0, 0);
        for (int i = 0; i < 300; i++) cyc(0, '0, 16'h8000, '0, 0);
        cyc(0, '0, 16'h0001, 16'hF000, 0);
        cyc(0, 5'h10, '0, '0, 0);
        check("t5_pos_sat", rec_data[3*PW +: PW], 8'd254);
        cyc(0, '0, '0, '0, 1);

        // 6: async reset mid-collection with records queued
        do_reset();
        short_string(0);
        short_string(0);
        cyc(1, '0, '0, '0, 0);
        cyc(0, '0, 16'h0001, '0, 0);
        do_reset();
        short_string(0);
        check("t6_id", rec_data[RW-1 -: IW], 8'd0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b <= G; b++) rdn[b] = ($urandom_range(7) == 0);
            for (int g = 0; g < G; g++)
                rro[g*N +: N] = ($urandom_range(5) == 0) ? 4'hF : 4'($urandom);
            cyc($urandom_range(9) == 0, rdn, ($urandom_range(3) == 0) ? '0 : L'($urandom),
                rro, $urandom_range(2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
